// File: rtl/stream_mux_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
// Shared constants for the stream multiplexer: FSM state encoding, selection
// mode encoding and a ceil(log2) helper used to validate the channel-index
// width parameter at elaboration time.
// ---------------------------------------------------------------------------
package stream_mux_pkg;

    // Arbiter FSM: ARB = no packet open, PKT = grant locked to one channel
    localparam logic ST_ARB = 1'b0;
    localparam logic ST_PKT = 1'b1;

    // Selection mode: fixed select bus or round-robin
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Smallest r with 2**r >= value (value of 1 gives 0)
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first requesting channel
// after ptr, searching ptr+1, ptr+2, ... modulo CHANNELS.
//   req  in   CHANNELS  request vector, one bit per channel
//   ptr  in   SEL_W     channel served most recently (lowest priority)
//   idx  out  SEL_W     winning channel (meaningful only when any=1)
//   any  out  1         at least one request is present
// ---------------------------------------------------------------------------
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    idx,
    output logic                any
);

    // One extra bit so start+offset (at most 2*CHANNELS-2) never wraps
    localparam int CW = SEL_W + 1;
    localparam logic [CW-1:0] NCH = CW'(CHANNELS);

    logic [CW-1:0]         startIdx;
    logic [2*CHANNELS-1:0] doubled;
    logic [CHANNELS-1:0]   rotated;
    logic [CW-1:0]         winner;
    logic                  found;

    // Search starts one past the last served channel, wrapping at CHANNELS
    always_comb begin
        startIdx = {1'b0, ptr} + CW'(1);
        if (startIdx >= NCH) begin
            startIdx = startIdx - NCH;
        end
    end

    // Two copies of req side by side let a plain right shift act as a rotate
    assign doubled = {req, req};
    assign rotated = CHANNELS'(doubled >> startIdx);

    // Lowest set bit of the rotated vector, mapped back to a channel number
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && rotated[k]) begin
                found  = 1'b1;
                winner = startIdx + CW'(k);
            end
        end
        if (winner >= NCH) begin
            winner = winner - NCH;
        end
    end

    assign idx = SEL_W'(winner);
    assign any = |req;

endmodule

// File: rtl/stream_mux.sv
// ---------------------------------------------------------------------------
// stream_mux
// N-channel valid/ready stream multiplexer with a registered output stage.
// A channel is chosen by the S bus (mode=0) or round-robin (mode=1), and the
// grant is held from the first beat of a packet through its last beat.
//   clk        in   1               rising-edge clock
//   rst        in   1               asynchronous active-high reset
//   mode       in   1               0 = fixed select, 1 = round-robin
//   S          in   SEL_W           channel select for mode=0
//   in_data    in   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   CHANNELS        per-channel beat valid
//   in_last    in   CHANNELS        per-channel end-of-packet flag
//   in_ready   out  CHANNELS        per-channel accept, one-hot or zero
//   Y          out  WIDTH           registered output data
//   out_chan   out  SEL_W           source channel of the beat on Y
//   out_last   out  1               registered end-of-packet flag
//   out_valid  out  1               output register holds a beat
//   out_ready  in   1               consumer accept
// ---------------------------------------------------------------------------
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          S,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    if (SEL_W != int'(clog2(CHANNELS)) || CHANNELS < 2 || CHANNELS > 16) begin : g_bad_params
        $error("stream_mux: CHANNELS must be 2..16 and SEL_W must equal clog2(CHANNELS)");
    end

    logic             state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] lock_q, lock_d;
    logic [WIDTH-1:0] y_q;
    logic [SEL_W-1:0] chan_q;
    logic             last_q;
    logic             valid_q;

    logic [SEL_W-1:0] rrIdx;
    logic             rrAny;
    logic [SEL_W-1:0] cand;
    logic             candValid;
    logic             candLast;
    logic [WIDTH-1:0] candData;
    logic             candOk;
    logic             loadOk;
    logic             fire;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_pick (
        .req (in_valid),
        .ptr (ptr_q),
        .idx (rrIdx),
        .any (rrAny)
    );

    // Candidate channel: the locked channel while a packet is open,
    // otherwise whatever the current mode selects
    always_comb begin
        cand = lock_q;
        if (state_q == ST_ARB) begin
            cand = (mode == MODE_RR) ? rrIdx : S;
        end
    end

    // Fetch the candidate's valid/last/data. An out-of-range select matches
    // no channel, so it reads as not valid and nothing is granted.
    always_comb begin
        candValid = 1'b0;
        candLast  = 1'b0;
        candData  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cand == SEL_W'(i)) begin
                candValid = in_valid[i];
                candLast  = in_last[i];
                candData  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        if (state_q == ST_ARB && mode == MODE_RR) begin
            candOk = rrAny;
        end else begin
            candOk = candValid;
        end
    end

    // The output register accepts a beat when empty or emptying this cycle
    assign loadOk = ~valid_q | out_ready;
    assign fire   = loadOk & candOk;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = fire && (cand == SEL_W'(i));
        end
    end

    // Packet tracking: a non-last beat opens/keeps a lock, a last beat
    // closes it and records the channel as most recently served
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (fire) begin
            if (candLast) begin
                state_d = ST_ARB;
                ptr_d   = cand;
            end else begin
                state_d = ST_PKT;
                lock_d  = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ARB;
            ptr_q   <= SEL_W'(CHANNELS - 1);
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

    // Output stage: a load wins over a drain so a simultaneous transfer
    // keeps out_valid high; data fields are left alone on a plain drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            chan_q  <= '0;
            last_q  <= 1'b0;
        end else if (fire) begin
            valid_q <= 1'b1;
            y_q     <= candData;
            chan_q  <= cand;
            last_q  <= candLast;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign Y         = y_q;
    assign out_chan  = chan_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output. Selection is either by the external select bus or by round-robin arbitration. A grant is held for a whole packet, up to and including the beat with last set. The output is registered; the block merges several producer streams into one consumer, such as a shared adder datapath or result bus.

## Interface
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, select/channel-index width, must equal ceil(log2(CHANNELS))
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous and active-high
- mode  input  1  0 = fixed select by S, 1 = round-robin; sampled only in ARB
- S  input  SEL_W  channel select used when mode=0
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel beat valid
- in_last  input  CHANNELS  per-channel end-of-packet flag
- in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle
- Y  output  WIDTH  registered output data
- out_chan  output  SEL_W  source channel of the beat on Y
- out_last  output  1  registered last flag
- out_valid  output  1  Y/out_chan/out_last hold a beat
- out_ready  input  1  consumer accept

## Operation
- Transfer rules:
  - Input transfer on channel i: in_valid[i] & in_ready[i] at a rising edge.
  - Output transfer: out_valid & out_ready.
- Output register can load when it is empty or draining: load_ok = ~out_valid | out_ready.
- in_ready[i] = load_ok & (i == candidate) & candidate_ok. It is combinational from out_ready, state, mode, S, in_valid and ptr.
- State ARB (no packet open):
  - mode=0: candidate = S; candidate_ok = (S < CHANNELS) & in_valid[S].
  - mode=1: candidate = first i with in_valid[i], searching ptr+1, ptr+2, … mod CHANNELS; candidate_ok = |in_valid.
  - Transfer with in_last=1: stay ARB, ptr <= candidate.
  - Transfer with in_last=0: go PKT, lock <= candidate.
- State PKT:
  - candidate = lock; candidate_ok = in_valid[lock]. mode and S are ignored.
  - Transfer with in_last=1: go ARB, ptr <= lock.
  - Transfer with in_last=0: stay PKT.
  - Other channels are stalled regardless of their valid.
- On input transfer: Y <= channel data, out_chan <= candidate, out_last <= in_last[candidate], out_valid <= 1.
- Output transfer with no input transfer in the same cycle: out_valid <= 0. Y, out_chan and out_last keep their last values.
- Simultaneous output and input transfer: the register reloads; out_valid stays 1.
- Holding: out_valid=1 & out_ready=0 holds Y, out_chan and out_last stable, and all in_ready are 0.
- ptr only changes on a last-beat transfer; in mode=0, ptr still tracks the channel that completed a packet.
- Illegal select: S >= CHANNELS (non-power-of-two CHANNELS) grants nothing; all in_ready stay 0.
- Single requester in round-robin: granted back-to-back every cycle, one beat per clock.

## Timing
- Reset values (asynchronous, while rst=1): state=ARB, ptr=CHANNELS-1 (channel 0 has first priority), lock=0, out_valid=0, Y=0, out_chan=0, out_last=0.
- Reset mid-packet aborts the packet: the lock is dropped and the held output beat is discarded.
- Latency: input transfer at edge n gives out_valid=1 with that data after edge n.
- Throughput: 1 beat/cycle while out_ready=1.
- Bubble: none on a packet boundary; the next grant is computed in the same cycle the last beat leaves ARB/PKT.
- mode/S changes take effect in the first ARB cycle; changes during PKT are ignored.

## Structure
- Package stream_mux_pkg:
  - State encoding ST_ARB=1'b0, ST_PKT=1'b1.
  - Mode constants MODE_SEL=1'b0, MODE_RR=1'b1.
  - clog2 function used to check SEL_W.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[CHANNELS], ptr[SEL_W].
  - Outputs: idx[SEL_W], any.
  - Implement as a double-width request vector rotated by ptr+1, priority-encoded, un-rotated mod CHANNELS.

## Test plan
- Reset/idle: assert rst mid-stream with out_valid=1 → out_valid, Y, out_chan, out_last read 0 immediately; after release, all in_ready=0 with no in_valid.
- Fixed select: mode=0, S=2, ch2 sends 0x11, 0x22(last) with out_ready=1 → Y=0x11 then 0x22 on consecutive cycles, out_chan=2, out_last on 2nd beat; ch1 valid throughout but never ready.
- Round-robin fairness: mode=1, all four channels issue single-beat packets continuously → out_chan sequence 0,1,2,3,0,… with no idle cycles.
- Packet lock: mode=1, ch1 sends a 3-beat packet while ch0/ch3 are valid; flip S and mode mid-packet → all 3 ch1 beats are contiguous; next grant is ch3, then ch0.
- Backpressure: hold out_ready=0 for 5 cycles with one beat stored → Y stable, in_ready=0; on release, one output transfer and a reload in the same cycle, out_valid stays 1.
- Illegal select: CHANNELS=3, mode=0, S=3, all in_valid=1 → in_ready=0, out_valid stays 0.
